coherency_mem_ctrl: RTL and testbench

Memory-side responder for the MOESI coherency bus: accepts each granted bus broadcast, collects snoop results from the four cache controllers, and sources the fill line either from the dirty owner cache or from shared memory. It returns exactly one response to the requesting core. It also serializes M/O-eviction writebacks into shared memory. Sits between the coherency bus and shared memory, replacing the direct read-only bus-to-memory hookup.

---
 rtl/moesi_pkg.sv | 26 ++
 rtl/coherency_mem_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_coherency_mem_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/moesi_pkg.sv
// Shared MOESI coherency types: bus transaction codes and memory-controller FSM states.
package moesi_pkg;

    localparam int MOESI_NUM_CORES  = 4;
    localparam int MOESI_LINE_BYTES = 64;
    localparam int LINE_OFFSET_BITS = $clog2(MOESI_LINE_BYTES);
    localparam int CORE_ID_W        = $clog2(MOESI_NUM_CORES);

    typedef enum logic [1:0] {
        BUS_IDLE = 2'b00,
        BUS_RD   = 2'b01,
        BUS_RDX  = 2'b10,
        BUS_UPGR = 2'b11
    } bus_type_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SNOOP,
        ST_MEM_REQ,
        ST_MEM_WAIT,
        ST_OWNER_WAIT,
        ST_RESPOND,
        ST_WB_REQ
    } mem_ctrl_state_e;

endpackage

// File: rtl/coherency_mem_ctrl.sv
// Memory-side responder for the MOESI bus: snoop collection, owner/memory fill sourcing,
// single response per broadcast, and serialized M/O-eviction writebacks.
//
// state       | meaning
// ST_IDLE     | waiting for a writeback (priority) or a bus broadcast
// ST_SNOOP    | letting the caches settle, then sampling snoop vectors
// ST_MEM_REQ  | issuing the line read to shared memory
// ST_MEM_WAIT | waiting for the memory read data
// ST_OWNER_WAIT | waiting for the dirty owner to supply the line
// ST_RESPOND  | one-cycle fill/ack to the requesting core
// ST_WB_REQ   | issuing the writeback to shared memory
module coherency_mem_ctrl
    import moesi_pkg::*;
#(
    parameter int NUM_CORES  = MOESI_NUM_CORES,
    parameter int ADDR_WIDTH = 64,
    parameter int LINE_BYTES = MOESI_LINE_BYTES,
    parameter int DATA_WIDTH = LINE_BYTES * 8,
    parameter int SNOOP_WAIT = 1,
    parameter int TIMEOUT    = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         bus_valid,
    input  logic [1:0]                   bus_type,
    input  logic [ADDR_WIDTH-1:0]        bus_addr,
    input  logic [$clog2(NUM_CORES)-1:0] granted_core_id,
    output logic                         bus_accept,
    output logic                         bus_busy,
    input  logic [NUM_CORES-1:0]         snoop_resp,
    input  logic [NUM_CORES-1:0]         snoop_owner,
    input  logic                         snoop_data_valid,
    input  logic [DATA_WIDTH-1:0]        snoop_data,
    output logic [NUM_CORES-1:0]         resp_valid,
    output logic [DATA_WIDTH-1:0]        resp_data,
    output logic                         resp_shared,
    input  logic                         wb_valid,
    input  logic [ADDR_WIDTH-1:0]        wb_addr,
    input  logic [DATA_WIDTH-1:0]        wb_data,
    output logic                         wb_ready,
    output logic                         mem_req_valid,
    output logic                         mem_req_write,
    output logic [ADDR_WIDTH-1:0]        mem_req_addr,
    output logic [DATA_WIDTH-1:0]        mem_req_wdata,
    input  logic                         mem_req_ready,
    input  logic                         mem_resp_valid,
    input  logic [DATA_WIDTH-1:0]        mem_resp_rdata,
    output logic                         err_timeout
);

    localparam int CID_W   = $clog2(NUM_CORES);
    localparam int CNT_MAX = (TIMEOUT > SNOOP_WAIT) ? TIMEOUT : SNOOP_WAIT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    mem_ctrl_state_e        state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    bus_type_e              type_q, type_d;
    logic [CID_W-1:0]       core_q, core_d;
    logic                   shared_q, shared_d;
    logic [DATA_WIDTH-1:0]  data_q, data_d;
    logic                   mreq_valid_q, mreq_valid_d;
    logic                   mreq_write_q, mreq_write_d;
    logic [ADDR_WIDTH-1:0]  mreq_addr_q, mreq_addr_d;
    logic [DATA_WIDTH-1:0]  mreq_wdata_q, mreq_wdata_d;
    logic                   err_q, err_d;

    logic [NUM_CORES-1:0]   req_onehot;
    logic [NUM_CORES-1:0]   others_resp;
    logic [NUM_CORES-1:0]   others_own;
    logic                   timed_out;

    assign req_onehot  = NUM_CORES'(1) << core_q;
    assign others_resp = snoop_resp & ~req_onehot;
    assign others_own  = snoop_owner & ~req_onehot;
    assign timed_out   = (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + CNT_W'(1);
        addr_d       = addr_q;
        type_d       = type_q;
        core_d       = core_q;
        shared_d     = shared_q;
        data_d       = data_q;
        mreq_valid_d = mreq_valid_q;
        mreq_write_d = mreq_write_q;
        mreq_addr_d  = mreq_addr_q;
        mreq_wdata_d = mreq_wdata_q;
        err_d        = err_q;
        bus_accept   = 1'b0;
        wb_ready     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!rst && wb_valid) begin
                    wb_ready     = 1'b1;
                    mreq_valid_d = 1'b1;
                    mreq_write_d = 1'b1;
                    mreq_addr_d  = wb_addr;
                    mreq_wdata_d = wb_data;
                    state_d      = ST_WB_REQ;
                end else if (!rst && bus_valid && bus_type_e'(bus_type) != BUS_IDLE) begin
                    bus_accept = 1'b1;
                    addr_d     = bus_addr & ~ADDR_WIDTH'(LINE_BYTES - 1);
                    type_d     = bus_type_e'(bus_type);
                    core_d     = granted_core_id;
                    data_d     = '0;
                    shared_d   = 1'b0;
                    state_d    = ST_SNOOP;
                end
            end
            ST_SNOOP: begin
                if (cnt_q == CNT_W'(SNOOP_WAIT - 1)) begin
                    shared_d = (type_q == BUS_RD) && (|others_resp);
                    if (type_q == BUS_UPGR) begin
                        state_d = ST_RESPOND;
                    end else if (|others_own) begin
                        state_d = ST_OWNER_WAIT;
                    end else begin
                        mreq_valid_d = 1'b1;
                        mreq_write_d = 1'b0;
                        mreq_addr_d  = addr_q;
                        mreq_wdata_d = '0;
                        state_d      = ST_MEM_REQ;
                    end
                end
            end
            ST_MEM_REQ: begin
                if (mem_req_ready) begin
                    mreq_valid_d = 1'b0;
                    state_d      = ST_MEM_WAIT;
                end else if (timed_out) begin
                    mreq_valid_d = 1'b0;
                    err_d        = 1'b1;
                    data_d       = '0;
                    state_d      = ST_RESPOND;
                end
            end
            ST_MEM_WAIT: begin
                if (mem_resp_valid) begin
                    data_d  = mem_resp_rdata;
                    state_d = ST_RESPOND;
                end else if (timed_out) begin
                    err_d   = 1'b1;
                    data_d  = '0;
                    state_d = ST_RESPOND;
                end
            end
            ST_OWNER_WAIT: begin
                // The dirty owner keeps write-back responsibility; memory is not updated here.
                if (snoop_data_valid) begin
                    data_d  = snoop_data;
                    state_d = ST_RESPOND;
                end else if (timed_out) begin
                    err_d   = 1'b1;
                    data_d  = '0;
                    state_d = ST_RESPOND;
                end
            end
            ST_RESPOND: begin
                state_d = ST_IDLE;
            end
            ST_WB_REQ: begin
                if (mem_req_ready) begin
                    mreq_valid_d = 1'b0;
                    state_d      = ST_IDLE;
                end else if (timed_out) begin
                    mreq_valid_d = 1'b0;
                    err_d        = 1'b1;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d != state_q || state_q == ST_IDLE) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            addr_q       <= '0;
            type_q       <= BUS_IDLE;
            core_q       <= '0;
            shared_q     <= 1'b0;
            data_q       <= '0;
            mreq_valid_q <= 1'b0;
            mreq_write_q <= 1'b0;
            mreq_addr_q  <= '0;
            mreq_wdata_q <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            type_q       <= type_d;
            core_q       <= core_d;
            shared_q     <= shared_d;
            data_q       <= data_d;
            mreq_valid_q <= mreq_valid_d;
            mreq_write_q <= mreq_write_d;
            mreq_addr_q  <= mreq_addr_d;
            mreq_wdata_q <= mreq_wdata_d;
            err_q        <= err_d;
        end
    end

    assign bus_busy      = (state_q != ST_IDLE) || bus_accept;
    assign resp_valid    = (state_q == ST_RESPOND) ? req_onehot : '0;
    assign resp_data     = (state_q == ST_RESPOND) ? data_q : '0;
    assign resp_shared   = (state_q == ST_RESPOND) && shared_q;
    assign mem_req_valid = mreq_valid_q;
    assign mem_req_write = mreq_write_q;
    assign mem_req_addr  = mreq_addr_q;
    assign mem_req_wdata = mreq_wdata_q;
    assign err_timeout   = err_q;

endmodule

// File: tb/tb_coherency_mem_ctrl.sv
// Directed bench for coherency_mem_ctrl: memory, owner, upgrade, writeback, timeout and reset paths.
module tb_coherency_mem_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         bus_valid;
    logic [1:0]   bus_type;
    logic [63:0]  bus_addr;
    logic [1:0]   granted_core_id;
    logic         bus_accept;
    logic         bus_busy;
    logic [3:0]   snoop_resp;
    logic [3:0]   snoop_owner;
    logic         snoop_data_valid;
    logic [511:0] snoop_data;
    logic [3:0]   resp_valid;
    logic [511:0] resp_data;
    logic         resp_shared;
    logic         wb_valid;
    logic [63:0]  wb_addr;
    logic [511:0] wb_data;
    logic         wb_ready;
    logic         mem_req_valid;
    logic         mem_req_write;
    logic [63:0]  mem_req_addr;
    logic [511:0] mem_req_wdata;
    logic         mem_req_ready;
    logic         mem_resp_valid;
    logic [511:0] mem_resp_rdata;
    logic         err_timeout;

    int n_pass  = 0;
    int n_total = 0;

    coherency_mem_ctrl dut (
        .clk(clk), .rst(rst),
        .bus_valid(bus_valid), .bus_type(bus_type), .bus_addr(bus_addr),
        .granted_core_id(granted_core_id),
        .bus_accept(bus_accept), .bus_busy(bus_busy),
        .snoop_resp(snoop_resp), .snoop_owner(snoop_owner),
        .snoop_data_valid(snoop_data_valid), .snoop_data(snoop_data),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_shared(resp_shared),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .wb_ready(wb_ready),
        .mem_req_valid(mem_req_valid), .mem_req_write(mem_req_write),
        .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
        .mem_req_ready(mem_req_ready),
        .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    function automatic logic [511:0] pat(input logic [7:0] b);
        return {64{b}};
    endfunction

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance to the next cycle; inputs driven right after, outputs checked after settle.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic issue(input logic [1:0] t, input logic [63:0] a, input logic [1:0] core);
        bus_valid       = 1'b1;
        bus_type        = t;
        bus_addr        = a;
        granted_core_id = core;
    endtask

    initial begin
        int cyc;
        rst = 1'b1;
        bus_valid = 0; bus_type = 0; bus_addr = 0; granted_core_id = 0;
        snoop_resp = 0; snoop_owner = 0; snoop_data_valid = 0; snoop_data = 0;
        wb_valid = 0; wb_addr = 0; wb_data = 0;
        mem_req_ready = 0; mem_resp_valid = 0; mem_resp_rdata = 0;
        repeat (3) next_cycle();
        settle();
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_mem_req_valid", mem_req_valid, 0);
        chk("rst_bus_busy", bus_busy, 0);
        chk("rst_err", err_timeout, 0);
        rst = 1'b0;
        next_cycle();

        // bus_valid with IDLE type is ignored
        issue(2'b00, 64'h40, 2'd1);
        settle();
        chk("idle_type_accept", bus_accept, 0);
        chk("idle_type_busy", bus_busy, 0);
        next_cycle();
        bus_valid = 0;
        settle();
        chk("idle_type_busy_next", bus_busy, 0);

        // memory-path BUS_RD from core 2, zero-wait ready, latency 4
        next_cycle();
        issue(2'b01, 64'h1234, 2'd2);
        settle();
        chk("rd_accept_T", bus_accept, 1);
        chk("rd_busy_T", bus_busy, 1);
        next_cycle();                                  // T+1
        bus_valid = 0;
        settle();
        chk("rd_accept_T1", bus_accept, 0);
        chk("rd_memreq_T1", mem_req_valid, 0);
        next_cycle();                                  // T+2
        settle();
        chk("rd_memreq_T2", mem_req_valid, 1);
        chk("rd_memwrite_T2", mem_req_write, 0);
        chk("rd_addr_aligned", mem_req_addr, 64'h1200);
        mem_req_ready = 1;
        next_cycle();                                  // T+3
        mem_req_ready = 0;
        settle();
        chk("rd_memreq_dropped", mem_req_valid, 0);
        next_cycle();                                  // T+4
        next_cycle();                                  // T+5
        next_cycle();                                  // T+6
        mem_resp_valid = 1; mem_resp_rdata = pat(8'hA5);
        settle();
        chk("rd_resp_T6", resp_valid, 0);
        next_cycle();                                  // T+7
        mem_resp_valid = 0; mem_resp_rdata = 0;
        settle();
        chk("rd_resp_T7", resp_valid, 4'b0100);
        chk("rd_data", resp_data, pat(8'hA5));
        chk("rd_shared", resp_shared, 0);
        chk("rd_busy_respond", bus_busy, 1);
        next_cycle();
        settle();
        chk("rd_resp_after", resp_valid, 0);
        chk("rd_busy_after", bus_busy, 0);

        // owner path: core 0 reads, core 1 holds it dirty
        next_cycle();
        issue(2'b01, 64'h4040, 2'd0);
        settle();
        chk("own_accept", bus_accept, 1);
        next_cycle();                                  // T+1
        bus_valid = 0; snoop_resp = 4'b0010; snoop_owner = 4'b0010;
        next_cycle();                                  // T+2
        snoop_resp = 0; snoop_owner = 0;
        settle();
        chk("own_no_memreq_T2", mem_req_valid, 0);
        next_cycle();                                  // T+3
        settle();
        chk("own_no_memreq_T3", mem_req_valid, 0);
        next_cycle();                                  // T+4
        snoop_data_valid = 1; snoop_data = pat(8'h3C);
        settle();
        chk("own_resp_T4", resp_valid, 0);
        next_cycle();                                  // T+5
        snoop_data_valid = 0; snoop_data = 0;
        settle();
        chk("own_resp_T5", resp_valid, 4'b0001);
        chk("own_data", resp_data, pat(8'h3C));
        chk("own_shared", resp_shared, 1);
        chk("own_no_memreq_T5", mem_req_valid, 0);

        // requester's own snoop bits are masked: goes to memory, not shared
        next_cycle();
        next_cycle();
        issue(2'b01, 64'h8000, 2'd1);
        next_cycle();                                  // T+1
        bus_valid = 0; snoop_resp = 4'b0010; snoop_owner = 4'b0010;
        next_cycle();                                  // T+2
        snoop_resp = 0; snoop_owner = 0;
        settle();
        chk("mask_memreq", mem_req_valid, 1);
        mem_req_ready = 1;
        next_cycle();                                  // T+3
        mem_req_ready = 0;
        next_cycle();                                  // T+4
        mem_resp_valid = 1; mem_resp_rdata = pat(8'h5A);
        next_cycle();                                  // T+5
        mem_resp_valid = 0; mem_resp_rdata = 0;
        settle();
        chk("mask_resp", resp_valid, 4'b0010);
        chk("mask_shared", resp_shared, 0);
        chk("mask_data", resp_data, pat(8'h5A));

        // BUS_UPGR from core 3
        next_cycle();
        next_cycle();
        issue(2'b11, 64'h7000, 2'd3);
        settle();
        chk("upgr_accept", bus_accept, 1);
        next_cycle();                                  // T+1
        bus_valid = 0; snoop_resp = 4'b0001;
        settle();
        chk("upgr_resp_T1", resp_valid, 0);
        next_cycle();                                  // T+2
        snoop_resp = 0;
        settle();
        chk("upgr_resp_T2", resp_valid, 4'b1000);
        chk("upgr_data", resp_data, 0);
        chk("upgr_shared", resp_shared, 0);
        chk("upgr_no_memreq", mem_req_valid, 0);

        // writeback wins over a simultaneous broadcast
        next_cycle();
        next_cycle();
        wb_valid = 1; wb_addr = 64'h9000; wb_data = pat(8'h77);
        issue(2'b01, 64'h2000, 2'd1);
        settle();
        chk("wb_ready_first", wb_ready, 1);
        chk("wb_no_accept", bus_accept, 0);
        next_cycle();                                  // T+1
        wb_valid = 0; wb_addr = 0; wb_data = 0;
        settle();
        chk("wb_memreq", mem_req_valid, 1);
        chk("wb_memwrite", mem_req_write, 1);
        chk("wb_addr", mem_req_addr, 64'h9000);
        chk("wb_wdata", mem_req_wdata, pat(8'h77));
        chk("wb_accept_blocked", bus_accept, 0);
        mem_req_ready = 1;
        next_cycle();                                  // T+2
        mem_req_ready = 0;
        settle();
        chk("wb_then_accept", bus_accept, 1);
        next_cycle();                                  // T+3
        bus_valid = 0;
        next_cycle();                                  // T+4
        settle();
        chk("wb_rd_memreq", mem_req_valid, 1);
        chk("wb_rd_read", mem_req_write, 0);
        chk("wb_rd_addr", mem_req_addr, 64'h2000);
        mem_req_ready = 1;
        next_cycle();                                  // T+5
        mem_req_ready = 0;
        next_cycle();                                  // T+6
        mem_resp_valid = 1; mem_resp_rdata = pat(8'h11);
        next_cycle();                                  // T+7
        mem_resp_valid = 0; mem_resp_rdata = 0;
        settle();
        chk("wb_rd_resp", resp_valid, 4'b0010);
        chk("wb_rd_data", resp_data, pat(8'h11));

        // timeout: mem_req_ready never asserted
        next_cycle();
        next_cycle();
        issue(2'b01, 64'h3000, 2'd0);
        next_cycle();
        bus_valid = 0;
        cyc = 1;
        while (resp_valid == 0 && cyc < 200) begin
            settle();
            if (cyc == 65) begin
                chk("to_err_before", err_timeout, 0);
                chk("to_memreq_before", mem_req_valid, 1);
            end
            next_cycle();
            cyc++;
        end
        settle();
        chk("to_resp_cycle", cyc, 66);
        chk("to_resp_valid", resp_valid, 4'b0001);
        chk("to_resp_data", resp_data, 0);
        chk("to_err", err_timeout, 1);
        chk("to_memreq_dropped", mem_req_valid, 0);
        next_cycle();
        settle();
        chk("to_idle_busy", bus_busy, 0);
        chk("to_err_sticky", err_timeout, 1);

        // reset while waiting for memory data
        next_cycle();
        issue(2'b01, 64'h5000, 2'd2);
        next_cycle();                                  // T+1
        bus_valid = 0;
        next_cycle();                                  // T+2
        mem_req_ready = 1;
        next_cycle();                                  // T+3 (MEM_WAIT)
        mem_req_ready = 0;
        rst = 1;
        next_cycle();                                  // T+4
        rst = 0;
        mem_resp_valid = 1; mem_resp_rdata = pat(8'hEE);
        settle();
        chk("rst_mid_resp", resp_valid, 0);
        chk("rst_mid_memreq", mem_req_valid, 0);
        chk("rst_mid_busy", bus_busy, 0);
        chk("rst_mid_err", err_timeout, 0);
        next_cycle();
        mem_resp_valid = 0; mem_resp_rdata = 0;
        settle();
        chk("rst_late_resp", resp_valid, 0);
        chk("rst_late_busy", bus_busy, 0);
        next_cycle();
        settle();
        chk("rst_late_resp2", resp_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
